// File: rtl/ahb_slave_port_mux_pkg.sv
// Shared AHB types and constants for the slave-side port mux.
package ahb_slave_port_mux_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_type;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'b000,
    BURST_INCR   = 3'b001,
    BURST_WRAP4  = 3'b010,
    BURST_INCR4  = 3'b011,
    BURST_WRAP8  = 3'b100,
    BURST_INCR8  = 3'b101,
    BURST_WRAP16 = 3'b110,
    BURST_INCR16 = 3'b111
  } hburst_type;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_ERR2 = 2'b10
  } resp_state_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // NONSEQ and SEQ are the only transfer types that open a data phase
  function automatic logic is_active(htrans_type t);
    return (t == TRANS_NONSEQ) || (t == TRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_slave_port_mux_if.sv
// Bus bundle between masters/arbiter/slave and the port mux.
// slave modport: the mux's view. master modport: the surrounding system's view.
interface ahb_slave_port_mux_if #(
  parameter int SLAVE_X_MASTER_NUM = 2,
  parameter int ADDR_WIDTH         = 32,
  parameter int DATA_WIDTH         = 32
);
  import ahb_slave_port_mux_pkg::*;

  localparam int N = SLAVE_X_MASTER_NUM;

  logic [N-1:0]                 hgrant;
  logic [N-1:0][ADDR_WIDTH-1:0] m_haddr;
  logic [N-1:0][1:0]            m_htrans;
  logic [N-1:0]                 m_hwrite;
  logic [N-1:0][2:0]            m_hsize;
  logic [N-1:0][2:0]            m_hburst;
  logic [N-1:0][DATA_WIDTH-1:0] m_hwdata;
  logic [N-1:0]                 m_hready;
  logic [N-1:0]                 m_hresp;
  logic [DATA_WIDTH-1:0]        m_hrdata;

  logic                         s_hsel;
  logic [ADDR_WIDTH-1:0]        s_haddr;
  htrans_type                   s_htrans;
  logic                         s_hwrite;
  logic [2:0]                   s_hsize;
  hburst_type                   s_hburst;
  logic [DATA_WIDTH-1:0]        s_hwdata;
  logic                         s_hreadyout;
  logic                         s_hresp;
  logic [DATA_WIDTH-1:0]        s_hrdata;

  logic                         hwait;
  hburst_type                   hburst;
  logic                         grant_err;

  modport slave (
    input  hgrant, m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hwdata,
    output m_hready, m_hresp, m_hrdata,
    output s_hsel, s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hwdata,
    input  s_hreadyout, s_hresp, s_hrdata,
    output hwait, hburst, grant_err
  );

  modport master (
    output hgrant, m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hwdata,
    input  m_hready, m_hresp, m_hrdata,
    input  s_hsel, s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hwdata,
    output s_hreadyout, s_hresp, s_hrdata,
    input  hwait, hburst, grant_err
  );

endinterface

// File: rtl/ahb_slave_port_mux_onehot_mux.sv
// One-hot select mux; zero output on a zero or multi-hot select.
module ahb_slave_port_mux_onehot_mux #(
  parameter int REQ_NUM = 2,
  parameter int WIDTH   = 32
) (
  input  logic [REQ_NUM-1:0]            sel_i,
  input  logic [REQ_NUM-1:0][WIDTH-1:0] data_i,
  output logic [WIDTH-1:0]              data_o,
  output logic                          valid_o
);

  // AND-OR select, gated by select validity
  always_comb begin
    valid_o = $onehot(sel_i);
    data_o  = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      data_o = data_o | (data_i[i] & {WIDTH{valid_o & sel_i[i]}});
    end
  end

endmodule

// File: rtl/ahb_slave_port_mux.sv
// Slave-side AHB port mux: forwards the granted master's address phase,
// tracks the data-phase owner and routes write data and responses.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no data phase in progress (downer = 0)
// ST_DATA | data phase owned by downer, waiting for hreadyout
// ST_ERR2 | second cycle of an ERROR response; new transfers blocked
module ahb_slave_port_mux
  import ahb_slave_port_mux_pkg::*;
#(
  parameter int SLAVE_X_MASTER_NUM = 2,
  parameter int ADDR_WIDTH         = 32,
  parameter int DATA_WIDTH         = 32
) (
  input logic                hclk,
  input logic                hreset_n,
  ahb_slave_port_mux_if.slave bus
);

  localparam int N      = SLAVE_X_MASTER_NUM;
  localparam int CTRL_W = ADDR_WIDTH + 2 + 1 + 3 + 3;

  logic [N-1:0][CTRL_W-1:0] ctrl_in;
  logic [CTRL_W-1:0]        ctrl_sel;
  logic                     addr_valid;
  logic                     data_valid;
  htrans_type               owner_htrans;
  logic                     accept;
  logic                     rdy;
  logic [N-1:0]             downer_q, downer_d;
  resp_state_t              state_q;
  logic                     grant_err_q;

  // Pack each master's address/control into one word for the grant mux
  always_comb begin
    for (int i = 0; i < N; i++) begin
      ctrl_in[i] = {bus.m_haddr[i], bus.m_htrans[i], bus.m_hwrite[i],
                    bus.m_hsize[i], bus.m_hburst[i]};
    end
  end

  ahb_slave_port_mux_onehot_mux #(.REQ_NUM(N), .WIDTH(CTRL_W)) u_addr_mux (
    .sel_i   (bus.hgrant),
    .data_i  (ctrl_in),
    .data_o  (ctrl_sel),
    .valid_o (addr_valid)
  );

  // Write data follows the registered data-phase owner
  ahb_slave_port_mux_onehot_mux #(.REQ_NUM(N), .WIDTH(DATA_WIDTH)) u_wdata_mux (
    .sel_i   (downer_q),
    .data_i  (bus.m_hwdata),
    .data_o  (bus.s_hwdata),
    .valid_o (data_valid)
  );

  // Address phase outputs, effective ready and next data owner
  always_comb begin
    owner_htrans  = htrans_type'(ctrl_sel[8:7]);
    bus.s_hsel    = addr_valid;
    bus.s_haddr   = ctrl_sel[CTRL_W-1 -: ADDR_WIDTH];
    bus.s_hwrite  = ctrl_sel[6];
    bus.s_hsize   = ctrl_sel[5:3];
    bus.s_hburst  = hburst_type'(ctrl_sel[2:0]);
    bus.hburst    = addr_valid ? hburst_type'(ctrl_sel[2:0]) : BURST_SINGLE;
    // the master sees the error on its second cycle; nothing new may start
    bus.s_htrans  = (state_q == ST_ERR2) ? TRANS_IDLE : owner_htrans;
    accept        = addr_valid & is_active(bus.s_htrans);
    // with no data phase pending the slave's hreadyout is irrelevant
    rdy           = data_valid ? bus.s_hreadyout : 1'b1;
    downer_d      = downer_q;
    if (rdy) begin
      downer_d = accept ? bus.hgrant : '0;
    end
  end

  // Per-master response routing
  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.m_hready[i] = ((addr_valid & bus.hgrant[i]) | downer_q[i]) & rdy;
      bus.m_hresp[i]  = downer_q[i] ? bus.s_hresp : HRESP_OKAY;
    end
    bus.m_hrdata  = bus.s_hrdata;
    bus.hwait     = data_valid & ~bus.s_hreadyout;
    bus.grant_err = grant_err_q;
  end

  // Response FSM, data-owner register and sticky grant error
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q     <= ST_IDLE;
      downer_q    <= '0;
      grant_err_q <= 1'b0;
    end else begin
      downer_q    <= downer_d;
      grant_err_q <= grant_err_q | ((|bus.hgrant) & ~addr_valid);
      case (state_q)
        ST_IDLE: if (rdy && accept) state_q <= ST_DATA;
        ST_DATA: begin
          if (bus.s_hresp == HRESP_ERROR && !bus.s_hreadyout) state_q <= ST_ERR2;
          else if (rdy && !accept)                            state_q <= ST_IDLE;
        end
        ST_ERR2: if (bus.s_hreadyout) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
